// File: rtl/polar_encoder_if.sv
// Stream interface for the polar encoder: P-bit message/frozen beats in, P-bit codeword beats out.
interface polar_encoder_if #(
  parameter int P = 64
) ();
  logic         in_valid;
  logic         in_ready;
  logic [P-1:0] u_in;
  logic [P-1:0] frz_in;
  logic         out_valid;
  logic         out_ready;
  logic [P-1:0] x_out;
  logic         out_last;
  logic         busy;

  modport master (
    output in_valid, u_in, frz_in, out_ready,
    input  in_ready, out_valid, x_out, out_last, busy
  );

  modport slave (
    input  in_valid, u_in, frz_in, out_ready,
    output in_ready, out_valid, x_out, out_last, busy
  );
endinterface

// File: rtl/polar_encoder.sv
// Non-systematic polar encoder: load N bits in P-bit beats, run N_LOG butterfly stages, stream out.
// Optional macro BIT_REVERSE_EN emits the codeword in bit-reversed index order.
module polar_encoder #(
  parameter int N     = 1024,
  parameter int N_LOG = 10,
  parameter int P     = 64
) (
  input  logic           clk,
  input  logic           rst,
  polar_encoder_if.slave bus
);
  localparam int BEATS = N / P;
  localparam int K_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int S_W   = $clog2(N_LOG + 1);
  localparam int SLOTS = 1 << S_W;
  localparam logic [K_W-1:0] LAST_BEAT  = K_W'(BEATS - 1);
  localparam logic [S_W-1:0] LAST_STAGE = S_W'(N_LOG - 1);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    ENC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t         state_reg, state_next;
  logic [K_W-1:0] beat_reg, beat_next;
  logic [S_W-1:0] stage_reg, stage_next;
  logic [N-1:0]   code_reg, code_next;

  logic [P-1:0]   masked;
  logic [N-1:0]   load_vec;
  logic [N-1:0]   stage_vec [SLOTS];
  logic [N-1:0]   ordered;
  logic [P-1:0]   beat_words [BEATS];

  genvar gi, gs;

  assign masked = bus.u_in & ~bus.frz_in;

  generate
    for (gi = 0; gi < BEATS; gi++) begin : g_load
      assign load_vec[gi*P +: P] = (beat_reg == K_W'(gi)) ? masked : code_reg[gi*P +: P];
    end
  endgenerate

  // One precomputed butterfly result per stage; slots past N_LOG pass through so the
  // stage counter can index the array without range concerns.
  generate
    for (gs = 0; gs < SLOTS; gs++) begin : g_stage
      for (gi = 0; gi < N; gi++) begin : g_bit
        if ((gs < N_LOG) && (((gi >> gs) & 1) == 0)) begin : g_xor
          assign stage_vec[gs][gi] = code_reg[gi] ^ code_reg[gi + (1 << gs)];
        end else begin : g_pass
          assign stage_vec[gs][gi] = code_reg[gi];
        end
      end
    end
  endgenerate

`ifdef BIT_REVERSE_EN
  function automatic int bitrev(input int v);
    int r;
    r = 0;
    for (int b = 0; b < N_LOG; b++) begin
      if (((v >> b) & 1) != 0) r = r | (1 << (N_LOG - 1 - b));
    end
    return r;
  endfunction

  generate
    for (gi = 0; gi < N; gi++) begin : g_rev
      assign ordered[gi] = code_reg[bitrev(gi)];
    end
  endgenerate
`else
  assign ordered = code_reg;
`endif

  generate
    for (gi = 0; gi < BEATS; gi++) begin : g_words
      assign beat_words[gi] = ordered[gi*P +: P];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= LOAD;
      beat_reg  <= '0;
      stage_reg <= '0;
      code_reg  <= '0;
    end else begin
      state_reg <= state_next;
      beat_reg  <= beat_next;
      stage_reg <= stage_next;
      code_reg  <= code_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    stage_next = stage_reg;
    code_next  = code_reg;
    case (state_reg)
      LOAD: begin
        if (bus.in_valid) begin
          code_next = load_vec;
          if (beat_reg == LAST_BEAT) begin
            beat_next  = '0;
            stage_next = '0;
            state_next = ENC;
          end else begin
            beat_next = beat_reg + K_W'(1);
          end
        end
      end
      ENC: begin
        code_next  = stage_vec[stage_reg];
        stage_next = stage_reg + S_W'(1);
        if (stage_reg == LAST_STAGE) state_next = OUT;
      end
      OUT: begin
        if (bus.out_ready) begin
          if (beat_reg == LAST_BEAT) begin
            beat_next  = '0;
            state_next = LOAD;
          end else begin
            beat_next = beat_reg + K_W'(1);
          end
        end
      end
      default: state_next = LOAD;
    endcase
  end

  assign bus.in_ready  = (state_reg == LOAD);
  assign bus.out_valid = (state_reg == OUT);
  assign bus.out_last  = (state_reg == OUT) && (beat_reg == LAST_BEAT);
  assign bus.busy      = (state_reg != LOAD);
  assign bus.x_out     = (state_reg == OUT) ? beat_words[beat_reg] : '0;

endmodule
